// File: rtl/game_control_levels.sv
// Multi-level game sequencer: drives MM/FM/SM load/reveal/reset strobes and
// keeps level, lives and per-attempt time-left counters for status display.
module game_control_levels #(
  parameter int unsigned NUM_LEVELS = 4,
  parameter int unsigned NUM_LIVES  = 3,
  parameter int unsigned TIME_LIMIT = 1000,
  parameter int unsigned LVL_W      = 2,
  parameter int unsigned LIFE_W     = 2,
  parameter int unsigned TIME_W     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              win,
  input  logic              lose,
  output logic              ldMM,
  output logic              ldMMtoSM,
  output logic              resetMM,
  output logic              resetFM,
  output logic              resetSM,
  output logic [LVL_W-1:0]  level,
  output logic [LIFE_W-1:0] lives,
  output logic [TIME_W-1:0] time_left,
  output logic              game_over,
  output logic              won
);

  typedef enum logic [3:0] {
    S_LOAD_MM      = 4'd0,
    S_LOAD_MM_WAIT = 4'd1,
    S_GAME_STATE   = 4'd2,
    S_LEVEL_UP     = 4'd3,
    S_LIFE_LOST    = 4'd4,
    S_RETRY        = 4'd5,
    S_GAME_WIN     = 4'd6,
    S_GAME_LOSE    = 4'd7,
    S_RESET        = 4'd8
  } state_t;

  localparam logic [LVL_W-1:0]  LVL_LAST   = LVL_W'(NUM_LEVELS - 1);
  localparam logic [LIFE_W-1:0] LIVES_INIT = LIFE_W'(NUM_LIVES);
  localparam logic [TIME_W-1:0] TIME_INIT  = TIME_W'(TIME_LIMIT);
  localparam bit                TIMER_ON   = (TIME_LIMIT != 0);

  state_t              r_state;
  state_t              w_next;
  logic [LVL_W-1:0]    r_level;
  logic [LVL_W-1:0]    w_level_nxt;
  logic [LIFE_W-1:0]   r_lives;
  logic [LIFE_W-1:0]   w_lives_nxt;
  logic [TIME_W-1:0]   r_time;
  logic [TIME_W-1:0]   w_time_nxt;
  logic                w_timeout;

  assign w_timeout = TIMER_ON && (r_time == TIME_W'(1));

  assign level     = r_level;
  assign lives     = r_lives;
  assign time_left = r_time;

  // State and counter registers; reset overrides any state mid-game
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_LOAD_MM;
      r_level <= '0;
      r_lives <= LIVES_INIT;
      r_time  <= TIME_INIT;
    end else begin
      r_state <= w_next;
      r_level <= w_level_nxt;
      r_lives <= w_lives_nxt;
      r_time  <= w_time_nxt;
    end
  end

  // Next-state, counter updates and Moore strobe decode
  always_comb begin
    w_next      = r_state;
    w_level_nxt = r_level;
    w_lives_nxt = r_lives;
    w_time_nxt  = r_time;
    ldMM        = 1'b0;
    ldMMtoSM    = 1'b0;
    resetMM     = 1'b0;
    resetFM     = 1'b0;
    resetSM     = 1'b0;
    game_over   = 1'b0;
    won         = 1'b0;
    case (r_state)
      S_LOAD_MM: begin
        ldMM = 1'b1;
        if (go) w_next = S_LOAD_MM_WAIT;
      end
      S_LOAD_MM_WAIT: begin
        if (!go) begin
          w_next     = S_GAME_STATE;
          w_time_nxt = TIME_INIT;
        end
      end
      S_GAME_STATE: begin
        if (TIMER_ON && (r_time != '0)) w_time_nxt = r_time - TIME_W'(1);
        // win outranks a simultaneous timeout; win&lose together is ignored
        if (win && !lose) begin
          w_next = (r_level == LVL_LAST) ? S_GAME_WIN : S_LEVEL_UP;
        end else if ((!win && lose) || w_timeout) begin
          if (r_lives == LIFE_W'(1)) begin
            w_next = S_GAME_LOSE;
          end else begin
            w_next      = S_LIFE_LOST;
            w_lives_nxt = r_lives - LIFE_W'(1);
          end
        end
      end
      S_LEVEL_UP: begin
        resetMM     = 1'b1;
        resetFM     = 1'b1;
        resetSM     = 1'b1;
        w_level_nxt = r_level + LVL_W'(1);
        w_next      = S_LOAD_MM;
      end
      S_LIFE_LOST: begin
        ldMMtoSM = 1'b1;
        if (go) w_next = S_RETRY;
      end
      S_RETRY: begin
        // master memory is kept so the same pattern is replayed
        resetFM = 1'b1;
        resetSM = 1'b1;
        w_next  = S_LOAD_MM_WAIT;
      end
      S_GAME_WIN: begin
        won       = 1'b1;
        game_over = 1'b1;
        if (go) w_next = S_RESET;
      end
      S_GAME_LOSE: begin
        ldMMtoSM  = 1'b1;
        game_over = 1'b1;
        if (go) w_next = S_RESET;
      end
      S_RESET: begin
        resetMM     = 1'b1;
        resetFM     = 1'b1;
        resetSM     = 1'b1;
        w_level_nxt = '0;
        w_lives_nxt = LIVES_INIT;
        w_next      = S_LOAD_MM;
      end
      default: w_next = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_game_control_levels.sv
// Directed bench for game_control_levels: two instances share stimulus, one
// with default sizing and a long timer, one with two levels and an 8-cycle timer.
module tb_game_control_levels;

  logic clk = 1'b0;
  logic reset, go, win, lose;

  logic       ldMM_a, ldMMtoSM_a, resetMM_a, resetFM_a, resetSM_a, game_over_a, won_a;
  logic [1:0] level_a, lives_a;
  logic [9:0] time_a;
  logic       ldMM_b, ldMMtoSM_b, resetMM_b, resetFM_b, resetSM_b, game_over_b, won_b;
  logic [1:0] level_b, lives_b;
  logic [9:0] time_b;

  logic [6:0] st_a, st_b;

  int n_total = 0;
  int n_bad   = 0;

  // strobe snapshot order: {ldMM, ldMMtoSM, resetMM, resetFM, resetSM, game_over, won}
  localparam logic [6:0] P_LOAD = 7'h40;
  localparam logic [6:0] P_NONE = 7'h00;
  localparam logic [6:0] P_RST3 = 7'h1C;
  localparam logic [6:0] P_LOST = 7'h20;
  localparam logic [6:0] P_RTRY = 7'h0C;
  localparam logic [6:0] P_WIN  = 7'h03;
  localparam logic [6:0] P_LOSE = 7'h22;

  assign st_a = {ldMM_a, ldMMtoSM_a, resetMM_a, resetFM_a, resetSM_a, game_over_a, won_a};
  assign st_b = {ldMM_b, ldMMtoSM_b, resetMM_b, resetFM_b, resetSM_b, game_over_b, won_b};

  always #5 clk = ~clk;

  game_control_levels #(
    .NUM_LEVELS(4), .NUM_LIVES(3), .TIME_LIMIT(1000),
    .LVL_W(2), .LIFE_W(2), .TIME_W(10)
  ) dut_a (
    .clk(clk), .reset(reset), .go(go), .win(win), .lose(lose),
    .ldMM(ldMM_a), .ldMMtoSM(ldMMtoSM_a), .resetMM(resetMM_a),
    .resetFM(resetFM_a), .resetSM(resetSM_a), .level(level_a),
    .lives(lives_a), .time_left(time_a), .game_over(game_over_a), .won(won_a)
  );

  game_control_levels #(
    .NUM_LEVELS(2), .NUM_LIVES(3), .TIME_LIMIT(8),
    .LVL_W(2), .LIFE_W(2), .TIME_W(10)
  ) dut_b (
    .clk(clk), .reset(reset), .go(go), .win(win), .lose(lose),
    .ldMM(ldMM_b), .ldMMtoSM(ldMMtoSM_b), .resetMM(resetMM_b),
    .resetFM(resetFM_b), .resetSM(resetSM_b), .level(level_b),
    .lives(lives_b), .time_left(time_b), .game_over(game_over_b), .won(won_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; go = 1'b0; win = 1'b0; lose = 1'b0;
    step(1);
    reset = 1'b0;
  endtask

  // LOAD_MM -> WAIT -> GAME
  task automatic enter_play();
    go = 1'b1; step(1);
    go = 1'b0; step(1);
  endtask

  // LIFE_LOST -> RETRY -> WAIT -> GAME
  task automatic retry();
    go = 1'b1; step(1);
    check("retry_strobes", st_a, P_RTRY);
    step(1);
    check("wait_strobes", st_a, P_NONE);
    go = 1'b0; step(1);
  endtask

  initial begin
    reset = 1'b0; go = 1'b0; win = 1'b0; lose = 1'b0;
    #2;

    // reset state
    do_reset();
    check("rst_strobes", st_a, P_LOAD);
    check("rst_level", level_a, 0);
    check("rst_lives", lives_a, 3);
    check("rst_time_a", time_a, 1000);
    check("rst_time_b", time_b, 8);

    // T1: first win goes through one LEVEL_UP cycle
    enter_play();
    check("t1_play", st_a, P_NONE);
    check("t1_time", time_a, 1000);
    win = 1'b1; step(1);
    check("t1_lvlup", st_a, P_RST3);
    check("t1_lvl_hold", level_a, 0);
    win = 1'b0; step(1);
    check("t1_load", st_a, P_LOAD);
    check("t1_level", level_a, 1);

    // T2: two-level game won, then go restarts via S_RESET
    do_reset();
    enter_play();
    win = 1'b1; step(1);
    check("t2_lvlup", st_b, P_RST3);
    win = 1'b0; step(1);
    check("t2_level1", level_b, 1);
    enter_play();
    win = 1'b1; step(1);
    win = 1'b0;
    check("t2_win", st_b, P_WIN);
    check("t2_win_lvl", level_b, 1);
    go = 1'b1; step(1);
    check("t2_reset", st_b, P_RST3);
    step(1);
    go = 1'b0;
    check("t2_load", st_b, P_LOAD);
    check("t2_level0", level_b, 0);
    check("t2_lives", lives_b, 3);

    // T3: three losses end the game
    do_reset();
    enter_play();
    lose = 1'b1; step(1); lose = 1'b0;
    check("t3_lost1", st_a, P_LOST);
    check("t3_lives2", lives_a, 2);
    retry();
    lose = 1'b1; step(1); lose = 1'b0;
    check("t3_lost2", st_a, P_LOST);
    check("t3_lives1", lives_a, 1);
    retry();
    lose = 1'b1; step(1); lose = 1'b0;
    check("t3_gamelose", st_a, P_LOSE);
    check("t3_lives_end", lives_a, 1);
    go = 1'b1; step(1);
    check("t3_reset", st_a, P_RST3);
    step(1); go = 1'b0;
    check("t3_lives_rst", lives_a, 3);

    // T4: timeout after 8 cycles of play
    do_reset();
    enter_play();
    check("t4_entry", time_b, 8);
    step(7);
    check("t4_t1", time_b, 1);
    check("t4_still", st_b, P_NONE);
    step(1);
    check("t4_lost", st_b, P_LOST);
    check("t4_lives", lives_b, 2);
    check("t4_time0", time_b, 0);
    check("t4_a_dec", time_a, 992);
    go = 1'b1; step(2);
    check("t4_hold", time_b, 0);
    go = 1'b0; step(1);
    check("t4_reload", time_b, 8);

    // T5: win&lose ignored; win beats a same-cycle timeout
    do_reset();
    enter_play();
    win = 1'b1; lose = 1'b1; step(5);
    check("t5_stay", st_a, P_NONE);
    check("t5_lives", lives_a, 3);
    check("t5_time", time_a, 995);
    win = 1'b0; lose = 1'b0; step(2);
    check("t5_b_t1", time_b, 1);
    win = 1'b1; step(1); win = 1'b0;
    check("t5_b_lvlup", st_b, P_RST3);
    check("t5_b_lives", lives_b, 3);

    // T6: reset from LIFE_LOST at level 2
    do_reset();
    enter_play();
    win = 1'b1; step(1); win = 1'b0; step(1);
    enter_play();
    win = 1'b1; step(1); win = 1'b0; step(1);
    enter_play();
    lose = 1'b1; step(1); lose = 1'b0;
    check("t6_lost", st_a, P_LOST);
    check("t6_level2", level_a, 2);
    reset = 1'b1; step(1); reset = 1'b0;
    check("t6_strobes", st_a, P_LOAD);
    check("t6_level", level_a, 0);
    check("t6_lives", lives_a, 3);
    check("t6_time", time_a, 1000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
